// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side valid/ready buses for mem_arbiter.
// Requesters connect as master to mem_arbiter_req_if; the arbiter is master on mem_arbiter_mem_if.

interface mem_arbiter_req_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 6
);
   logic                  valid;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic                  ready;
   logic [WIDTH-1:0]      rdata;
   logic                  err;

   modport master (output valid, wr_rd, addr, wdata, input  ready, rdata, err);
   modport slave  (input  valid, wr_rd, addr, wdata, output ready, rdata, err);
endinterface

interface mem_arbiter_mem_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 6
);
   logic                  valid;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic                  ready;
   logic [WIDTH-1:0]      rdata;

   modport master (output valid, wr_rd, addr, wdata, input  ready, rdata);
   modport slave  (input  valid, wr_rd, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port valid/ready memory.
// Optional ISSUE timeout abort is enabled with `define MEM_ARB_TIMEOUT_EN.

module mem_arbiter #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
   input  logic               clk_i,
   input  logic               rst_i,
   mem_arbiter_req_if.slave   req0,
   mem_arbiter_req_if.slave   req1,
   mem_arbiter_mem_if.master  mem,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef struct packed {
      logic                  wr_rd;
      logic [ADDR_WIDTH-1:0] addr;
      logic [WIDTH-1:0]      wdata;
   } cmd_t;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
`endif

   state_t           r_state,      w_state;
   cmd_t             r_cmd,        w_cmd;
   logic             r_grant,      w_grant;
   logic             r_last_grant, w_last_grant;
   logic             r_mem_valid,  w_mem_valid;
   logic             r_busy,       w_busy;
   logic [1:0]       r_ready,      w_ready;
   logic [WIDTH-1:0] r_rdata0,     w_rdata0;
   logic [WIDTH-1:0] r_rdata1,     w_rdata1;
`ifdef MEM_ARB_TIMEOUT_EN
   logic [1:0]        r_err,  w_err;
   logic [TCNT_W-1:0] r_tcnt, w_tcnt;
`endif

   logic w_req_any;
   logic w_win;
   cmd_t w_win_cmd;
   logic [WIDTH-1:0] w_resp_data;

   // Winner selection: a lone request wins; on a tie the side not served last wins.
   always_comb begin
      w_req_any = req0.valid | req1.valid;
      if (req0.valid && req1.valid) begin
         w_win = ~r_last_grant;
      end else begin
         w_win = req1.valid;
      end
      if (w_win) begin
         w_win_cmd = '{wr_rd: req1.wr_rd, addr: req1.addr, wdata: req1.wdata};
      end else begin
         w_win_cmd = '{wr_rd: req0.wr_rd, addr: req0.addr, wdata: req0.wdata};
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state      = r_state;
      w_cmd        = r_cmd;
      w_grant      = r_grant;
      w_last_grant = r_last_grant;
      w_mem_valid  = r_mem_valid;
      w_ready      = 2'b00;
      w_rdata0     = '0;
      w_rdata1     = '0;
      w_resp_data  = r_cmd.wr_rd ? '0 : mem.rdata;
`ifdef MEM_ARB_TIMEOUT_EN
      w_err        = 2'b00;
      w_tcnt       = r_tcnt;
`endif

      unique case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state     = ST_ISSUE;
               w_cmd       = w_win_cmd;
               w_grant     = w_win;
               w_mem_valid = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
               w_tcnt      = '0;
`endif
            end
         end

         ST_ISSUE: begin
            if (mem.ready) begin
               w_state          = ST_RESP;
               w_mem_valid      = 1'b0;
               w_ready[r_grant] = 1'b1;
               if (r_grant) begin
                  w_rdata1 = w_resp_data;
               end else begin
                  w_rdata0 = w_resp_data;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            // Abort on the last allowed stalled cycle; read data stays zero.
            else if (r_tcnt == TCNT_LAST) begin
               w_state          = ST_RESP;
               w_mem_valid      = 1'b0;
               w_ready[r_grant] = 1'b1;
               w_err[r_grant]   = 1'b1;
            end else begin
               w_tcnt = r_tcnt + TCNT_W'(1);
            end
`endif
         end

         ST_RESP: begin
            w_state      = ST_IDLE;
            w_last_grant = r_grant;
         end

         default: begin
            w_state     = ST_IDLE;
            w_mem_valid = 1'b0;
         end
      endcase

      w_busy = (w_state != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_cmd        <= '0;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_mem_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 2'b00;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         r_err        <= 2'b00;
         r_tcnt       <= '0;
`endif
      end else begin
         r_state      <= w_state;
         r_cmd        <= w_cmd;
         r_grant      <= w_grant;
         r_last_grant <= w_last_grant;
         r_mem_valid  <= w_mem_valid;
         r_busy       <= w_busy;
         r_ready      <= w_ready;
         r_rdata0     <= w_rdata0;
         r_rdata1     <= w_rdata1;
`ifdef MEM_ARB_TIMEOUT_EN
         r_err        <= w_err;
         r_tcnt       <= w_tcnt;
`endif
      end
   end

   assign mem.valid  = r_mem_valid;
   assign mem.wr_rd  = r_cmd.wr_rd;
   assign mem.addr   = r_cmd.addr;
   assign mem.wdata  = r_cmd.wdata;

   assign req0.ready = r_ready[0];
   assign req1.ready = r_ready[1];
   assign req0.rdata = r_rdata0;
   assign req1.rdata = r_rdata1;
   assign busy_o     = r_busy;

`ifdef MEM_ARB_TIMEOUT_EN
   assign req0.err = r_err[0];
   assign req1.err = r_err[1];
`else
   assign req0.err = 1'b0;
   assign req1.err = 1'b0;
`endif

endmodule
